// File: rtl/plot_step_driver.sv
// rtl/plot_step_driver.sv - cursor target to rate-limited step/dir pulses with pen control
// Commands are latched in IDLE only; each step slot is SETUP (dir), STEP (pulse), then WAIT.
module plot_step_driver #(
  parameter int STEP_PERIOD = 80000,
  parameter int PEN_SETTLE  = 40000,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  input  logic        pen_req,
  output logic        step_x,
  output logic        dir_x,
  output logic        step_y,
  output logic        dir_y,
  output logic        pen_down,
  output logic [11:0] head_x,
  output logic [11:0] head_y,
  output logic        busy,
  output logic        at_target
);

  typedef enum logic [2:0] {IDLE, PEN, SETUP, STEP, WAIT} state_t;

  localparam logic [11:0] X_LIM       = 12'(X_MAX);
  localparam logic [11:0] Y_LIM       = 12'(Y_MAX);
  localparam logic [19:0] SLOT_LAST   = 20'(STEP_PERIOD - 1);
  localparam logic [19:0] SETTLE_LAST = 20'(PEN_SETTLE - 1);

  state_t      state, next_state;
  logic [11:0] tx, ty, lx, ly;
  logic        lpen;
  logic [19:0] cnt;
  logic        pos_match_in, pos_match_lat;

  logic        step_x_nxt, step_y_nxt, dir_x_nxt, dir_y_nxt, pen_nxt;
  logic        busy_nxt, at_target_nxt, lpen_nxt;
  logic [11:0] head_x_nxt, head_y_nxt, lx_nxt, ly_nxt;
  logic [19:0] cnt_nxt;

  assign tx = (target_x > X_LIM) ? X_LIM : target_x;
  assign ty = (target_y > Y_LIM) ? Y_LIM : target_y;
  assign pos_match_in  = (head_x == tx) && (head_y == ty);
  assign pos_match_lat = (head_x == lx) && (head_y == ly);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      step_x    <= 1'b0;
      step_y    <= 1'b0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      pen_down  <= 1'b0;
      head_x    <= '0;
      head_y    <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      lx        <= '0;
      ly        <= '0;
      lpen      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      step_x    <= step_x_nxt;
      step_y    <= step_y_nxt;
      dir_x     <= dir_x_nxt;
      dir_y     <= dir_y_nxt;
      pen_down  <= pen_nxt;
      head_x    <= head_x_nxt;
      head_y    <= head_y_nxt;
      busy      <= busy_nxt;
      at_target <= at_target_nxt;
      lx        <= lx_nxt;
      ly        <= ly_nxt;
      lpen      <= lpen_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Pen changes take priority so the head never drags with the pen mid-transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable) begin
          if (pen_req != pen_down) next_state = PEN;
          else if (!pos_match_in)  next_state = SETUP;
        end
      end
      PEN:     if (cnt == SETTLE_LAST) next_state = pos_match_lat ? IDLE : SETUP;
      SETUP:   next_state = STEP;
      STEP:    next_state = WAIT;
      WAIT:    if (cnt == SLOT_LAST) next_state = (!enable || pos_match_lat) ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    step_x_nxt    = 1'b0;
    step_y_nxt    = 1'b0;
    dir_x_nxt     = dir_x;
    dir_y_nxt     = dir_y;
    pen_nxt       = pen_down;
    head_x_nxt    = head_x;
    head_y_nxt    = head_y;
    lx_nxt        = lx;
    ly_nxt        = ly;
    lpen_nxt      = lpen;
    busy_nxt      = (next_state != IDLE);
    at_target_nxt = (state == IDLE) && pos_match_in && (pen_down == pen_req);
    cnt_nxt       = cnt + 20'd1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (next_state != IDLE) begin
          lx_nxt   = tx;
          ly_nxt   = ty;
          lpen_nxt = pen_req;
        end
      end
      PEN:   pen_nxt = lpen;
      // Slot cycle 0: the STEP state counts as cycle 1.
      SETUP: begin
        cnt_nxt   = 20'd1;
        dir_x_nxt = (lx > head_x);
        dir_y_nxt = (ly > head_y);
      end
      STEP: begin
        if (lx != head_x) begin
          step_x_nxt = 1'b1;
          head_x_nxt = dir_x ? head_x + 12'd1 : head_x - 12'd1;
        end
        if (ly != head_y) begin
          step_y_nxt = 1'b1;
          head_y_nxt = dir_y ? head_y + 12'd1 : head_y - 12'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
